// File: rtl/mole_picker_if.sv
// Handshake bundle between the countdown stage, the mole picker and the display stage.
// The picker uses the slave modport; the requester/consumer side uses master.
interface mole_picker_if;
  logic       req;
  logic [3:0] mole;
  logic       valid;
  logic       busy;

  modport master (output req, input mole, input valid, input busy);
  modport slave  (input req, output mole, output valid, output busy);
endinterface

// File: rtl/mole_picker.sv
// Pseudo-random mole selector driven by a free-running 16-bit Galois LFSR.
// Define MOLE_PICKER_NO_REPEAT_EN to forbid the same mole on two consecutive draws.
module mole_picker #(
  parameter int          NUM_MOLES = 10,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic         clock,
  input  logic         clear_b,
  mole_picker_if.slave bus
);

  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  LAST_MOLE = 4'(NUM_MOLES - 1);
  localparam logic [4:0]  MOLE_LIM  = 5'(NUM_MOLES);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t      state_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [15:0] lfsr_shifted;
  logic [3:0]  tries_reg;
  logic [3:0]  mole_reg;
  logic        valid_reg;
  logic        busy_reg;

  logic [3:0]  candidate;
  logic        in_range;
  logic        repeat_ok;
  logic        accept;
  logic [3:0]  fallback_mole;

  // Right-shift Galois step: every tapped bit is flipped by the bit shifted out.
  assign lfsr_shifted = {1'b0, lfsr_reg[15:1]};
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
      assign lfsr_next[gi] = lfsr_shifted[gi] ^ (TAPS[gi] & lfsr_reg[0]);
    end
  endgenerate

  assign candidate = lfsr_reg[3:0];
  assign in_range  = {1'b0, candidate} < MOLE_LIM;

`ifdef MOLE_PICKER_NO_REPEAT_EN
  assign repeat_ok = (candidate != mole_reg);
`else
  assign repeat_ok = 1'b1;
`endif

  assign accept        = in_range && repeat_ok;
  assign fallback_mole = (mole_reg == LAST_MOLE) ? 4'd0 : mole_reg + 4'd1;

  always_ff @(posedge clock) begin
    if (!clear_b) begin
      lfsr_reg  <= SEED_INIT;
      state_reg <= IDLE;
      tries_reg <= 4'd0;
      mole_reg  <= 4'd0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      lfsr_reg  <= lfsr_next;
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            state_reg <= DRAW;
            tries_reg <= 4'd0;
            busy_reg  <= 1'b1;
          end
        end
        DRAW: begin
          if (accept) begin
            mole_reg  <= candidate;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (tries_reg == 4'd8) begin
            // Ninth rejected candidate: step to the next mole so the draw always ends.
            mole_reg  <= fallback_mole;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            tries_reg <= tries_reg + 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.mole  = mole_reg;
  assign bus.valid = valid_reg;
  assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_mole_picker.sv
// Self-checking bench for mole_picker: directed steps plus randomized draws checked
// against a per-draw reference model built from the LFSR rule and the acceptance rules.
module tb_mole_picker;

  localparam logic [15:0] TAPS = 16'hB400;
`ifdef MOLE_PICKER_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  logic clock   = 1'b0;
  logic clear_b = 1'b0;
  always #5 clock = ~clock;

  mole_picker_if if_a ();
  mole_picker_if if_b ();
  mole_picker_if if_z ();

  mole_picker #(.NUM_MOLES(10)) dut_a (.clock(clock), .clear_b(clear_b), .bus(if_a));
  mole_picker #(.NUM_MOLES(2))  dut_b (.clock(clock), .clear_b(clear_b), .bus(if_b));
  mole_picker #(.NUM_MOLES(10), .SEED(16'h0000)) dut_z (.clock(clock), .clear_b(clear_b), .bus(if_z));

  int          checks = 0;
  int          errors = 0;
  int          fallbacks = 0;
  logic [15:0] lfsr_m;
  logic [3:0]  mole_a_m;
  logic [3:0]  mole_b_m;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model LFSR follows the same edge (reseeded while clear_b is low).
  task automatic tick();
    @(posedge clock);
    lfsr_m = clear_b ? lfsr_step(lfsr_m) : 16'hACE1;
    #1;
  endtask

  function automatic logic get_valid(input int sel);
    return (sel == 0) ? if_a.valid : if_b.valid;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if_a.busy : if_b.busy;
  endfunction
  function automatic logic [3:0] get_mole(input int sel);
    return (sel == 0) ? if_a.mole : if_b.mole;
  endfunction
  task automatic set_req(input int sel, input logic v);
    if (sel == 0) if_a.req = v;
    else          if_b.req = v;
  endtask

  // Reference: candidates are the low nibbles of the next nine LFSR states after the req cycle.
  task automatic predict(input logic [15:0] l, input logic [3:0] prev, input int n,
                         output logic [3:0] m, output int lat, output bit fb);
    logic [15:0] v;
    bit          done;
    v    = l;
    done = 1'b0;
    fb   = 1'b1;
    lat  = 10;
    m    = 4'((int'(prev) + 1) % n);
    for (int k = 1; k <= 9; k++) begin
      v = lfsr_step(v);
      if (!done && int'(v[3:0]) < n && !(NO_REPEAT && v[3:0] == prev)) begin
        m    = v[3:0];
        lat  = k + 1;
        fb   = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic draw(input int sel, input int dup_at, output logic [3:0] got,
                      output int lat, output int busy_cnt);
    logic [3:0] exp_m;
    logic [3:0] prev;
    int         exp_lat;
    int         n;
    bit         fb;
    prev = (sel == 0) ? mole_a_m : mole_b_m;
    n    = (sel == 0) ? 10 : 2;
    predict(lfsr_m, prev, n, exp_m, exp_lat, fb);
    check("idle_busy", 32'(get_busy(sel)), 32'd0);
    set_req(sel, 1'b1);
    lat      = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      set_req(sel, 1'b0);
      if (get_valid(sel)) begin
        lat = k;
        break;
      end
      if (get_busy(sel)) busy_cnt++;
      if (k == dup_at && k < exp_lat) set_req(sel, 1'b1);
    end
    got = get_mole(sel);
    check("latency", lat, exp_lat);
    check("mole", 32'(got), 32'(exp_m));
    check("busy_cycles", busy_cnt, exp_lat - 1);
    check("busy_at_valid", 32'(get_busy(sel)), 32'd0);
    if (fb) fallbacks++;
    if (sel == 0) mole_a_m = exp_m;
    else          mole_b_m = exp_m;
    $display("draw dut=%0d lfsr_req=%04h mole=%0d lat=%0d fallback=%0d", sel, lfsr_m, got, lat, fb);
  endtask

  task automatic reset_all();
    clear_b = 1'b0;
    repeat (3) tick();
    mole_a_m = 4'd0;
    mole_b_m = 4'd0;
    check("rst_mole_a", 32'(if_a.mole), 32'd0);
    check("rst_valid_a", 32'(if_a.valid), 32'd0);
    check("rst_busy_a", 32'(if_a.busy), 32'd0);
    check("rst_mole_b", 32'(if_b.mole), 32'd0);
    check("rst_lfsr_a", 32'(dut_a.lfsr_reg), 32'h0000ACE1);
    check("rst_lfsr_seed0", 32'(dut_z.lfsr_reg), 32'h00000001);
    clear_b = 1'b1;
    $display("reset released");
  endtask

  initial begin
    logic [3:0]  got;
    logic [3:0]  prev_got;
    logic [3:0]  held;
    logic [15:0] lfsr_z_m;
    int          lat;
    int          bcnt;
    int          stray;
    int          zeros;
    int          first_ret;
    int          z_mism;

    if_a.req = 1'b0;
    if_b.req = 1'b0;
    if_z.req = 1'b0;
    reset_all();

    // First cycle after reset: lfsr is ACE1, candidates 0 then 8.
    draw(0, 0, got, lat, bcnt);
    check("dir_mole", 32'(got), NO_REPEAT ? 32'd8 : 32'd0);
    check("dir_latency", lat, NO_REPEAT ? 3 : 2);
    check("dir_busy_cycles", bcnt, NO_REPEAT ? 2 : 1);

    // Second req while busy is dropped: one valid, mole changes once.
    tick();
    draw(0, 1, got, lat, bcnt);
    held  = got;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if_a.valid) stray++;
    end
    check("dup_req_no_valid", stray, 0);
    check("dup_req_mole_held", 32'(if_a.mole), 32'(held));

    // Randomized draws on the 10-mole instance with random gaps and dropped reqs.
    for (int i = 0; i < 30; i++) begin
      stray = 0;
      repeat ($urandom_range(0, 3)) begin
        tick();
        if (if_a.valid) stray++;
      end
      check("gap_no_valid", stray, 0);
      draw(0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : 0, got, lat, bcnt);
    end

    // Back-to-back draws on the 2-mole instance.
    fallbacks = 0;
    prev_got  = mole_b_m;
    for (int i = 0; i < 200; i++) begin
      draw(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0, got, lat, bcnt);
      check("b_range", 32'(got < 4'd2), 32'd1);
      check("b_latency_bound", 32'(lat >= 2 && lat <= 10), 32'd1);
`ifdef MOLE_PICKER_NO_REPEAT_EN
      check("b_alternate", 32'(got != prev_got), 32'd1);
`endif
      prev_got = got;
    end
    check("b_fallback_seen", 32'(fallbacks > 0), 32'd1);

    // Reset during a draw aborts it and restarts the LFSR from its seed.
    tick();
    if_a.req = 1'b1;
    tick();
    if_a.req = 1'b0;
    check("abort_busy_before", 32'(if_a.busy), 32'd1);
    clear_b = 1'b0;
    tick();
    clear_b  = 1'b1;
    mole_a_m = 4'd0;
    mole_b_m = 4'd0;
    check("abort_lfsr_seed", 32'(dut_a.lfsr_reg), 32'h0000ACE1);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) check("abort_lfsr_step", 32'(dut_a.lfsr_reg), 32'h0000E270);
      if (if_a.valid) stray++;
    end
    check("abort_no_valid", stray, 0);
    check("abort_mole", 32'(if_a.mole), 32'd0);
    check("abort_busy", 32'(if_a.busy), 32'd0);
    $display("abort test done");

    // Zero seed: LFSR starts at 1, never hits 0 and has period 65535.
    reset_all();
    lfsr_z_m  = 16'h0001;
    zeros     = 0;
    first_ret = 0;
    z_mism    = 0;
    for (int s = 1; s <= 65535; s++) begin
      tick();
      lfsr_z_m = lfsr_step(lfsr_z_m);
      if (dut_z.lfsr_reg == 16'h0000) zeros++;
      if (dut_z.lfsr_reg != lfsr_z_m) z_mism++;
      if (dut_z.lfsr_reg == 16'h0001 && first_ret == 0) first_ret = s;
    end
    check("seed0_never_zero", zeros, 0);
    check("seed0_period", first_ret, 65535);
    check("seed0_sequence", z_mism, 0);
    $display("seed0 test done: period=%0d", first_ret);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_picker.md
# mole_picker

Pseudo-random mole selector for the whack-a-mole game. On each request pulse from the countdown stage it draws a mole index in 0..NUM_MOLES-1 from a free-running 16-bit LFSR. It presents the index with a one-cycle valid strobe. It sits directly upstream of the display stage, which loads `mole` into its display register when `valid` is high.

## Interface
- `NUM_MOLES`, default 10: number of moles; legal range 2..16.
- `SEED`, default 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- `clock` input 1: system clock (CLOCK_50).
- `clear_b` input 1: reset; synchronous, active-low.
- `req` input 1: draw request; single-cycle pulse, normally the countdown-reached-zero strobe.
- `mole` output 4: current mole index; holds its value between draws.
- `valid` output 1: one-cycle strobe; `mole` was updated on the same edge.
- `busy` output 1: draw in progress; `req` is ignored while high.

## Operation
- LFSR:
  - 16-bit Galois, right-shift form with taps mask 16'hB400.
  - Each step: `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`.
  - Advances every cycle while `clear_b`=1, regardless of state.
  - Never reaches 0.
- The candidate is `lfsr[3:0]`, compared as unsigned against NUM_MOLES.
- States:
  - IDLE: `busy`=0. On `req`=1: go to DRAW, `tries`<=0, `busy`<=1.
  - DRAW: evaluate the candidate each cycle.
    - Accept when candidate < NUM_MOLES and the repeat check passes (see Configuration). Then `mole`<=candidate, `valid`<=1, `busy`<=0, go to IDLE.
    - Otherwise `tries`<=`tries`+1 and stay in DRAW.
    - When `tries`==8 (9th DRAW cycle): fallback, `mole`<=(`mole`+1) mod NUM_MOLES, with `valid`, `busy` and the state change as for accept.
- `tries` is 4 bits and is cleared on every IDLE->DRAW transition.
- `req` in DRAW is dropped, not queued.
- `req` high in the same cycle as `valid` is accepted, since the state is already IDLE.
- Reset values:
  - `lfsr`=SEED (or 1 if SEED is 0).
  - `mole`=0, `valid`=0, `busy`=0, `tries`=0.
  - State IDLE.
- Reset mid-DRAW aborts the draw: no `valid` is issued and `mole` returns to 0.

## Timing
- `req` is sampled at edge E0; `busy` is high from E0.
- Best case: the accept is registered at E1, so `valid` and the new `mole` are visible in the cycle after E1.
- Worst case (fallback): `valid` follows E9, so latency is 2..10 cycles from the `req` cycle to the `valid` cycle.
- `valid` is exactly one cycle wide; `busy` falls on the same edge that `valid` rises.
- Throughput: at most one draw per 2 cycles.

## Configuration
- `MOLE_PICKER_NO_REPEAT_EN` defined:
  - A candidate equal to the current `mole` is rejected.
  - Consecutive draws are guaranteed distinct, including the fallback path, because NUM_MOLES >= 2.
- Not defined:
  - Only the range check applies, so repeats are allowed.
  - The fallback still yields (`mole`+1) mod NUM_MOLES.

## Test plan
- Default parameters, NO_REPEAT enabled; release `clear_b`, pulse `req` in the first cycle after reset (`lfsr`=ACE1):
  - DRAW sees candidate 0, equal to `mole`, and rejects it.
  - Next candidate 8 is accepted.
  - Required: `mole`=8, `valid` high exactly 3 cycles after the `req` cycle, `busy` high for 2 cycles.
- Same stimulus with NO_REPEAT undefined: candidate 0 is accepted, giving `mole`=0 and `valid` 2 cycles after `req`.
- NUM_MOLES=2, 200 back-to-back requests:
  - Every `mole` is in {0,1}.
  - With NO_REPEAT, values strictly alternate.
  - Every `valid` arrives within 10 cycles of its `req`.
  - Fallback count > 0 (check by probing `tries`==8).
- Pulse `req` again while `busy`=1: no second `valid`, and `mole` changes exactly once.
- Drop `clear_b` during DRAW, then release and idle 20 cycles: no `valid`, `mole`=0, `busy`=0, and `lfsr` restarts at ACE1 (first post-reset step gives E270).
- SEED=0: the LFSR starts at 0001, never equals 0 over 65535 cycles, and returns to 0001 after exactly 65535 steps.
